// File: rtl/router_ctrl_fsm_pkg.sv
// Shared types and constants for the router control FSM: state encoding,
// destination address values and the Moore output decode.
package router_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  localparam logic [1:0] ADDR0        = 2'd0;
  localparam logic [1:0] ADDR1        = 2'd1;
  localparam logic [1:0] ADDR2        = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  typedef struct packed {
    logic busy;
    logic detect_add;
    logic lfd_state;
    logic ld_state;
    logic full_state;
    logic laf_state;
    logic write_enb_reg;
    logic rst_int_reg;
  } ctrl_out_t;

  // Moore decode of a state into the full set of control strobes.
  function automatic ctrl_out_t decode_outputs(input state_t s);
    ctrl_out_t o;
    o = '0;
    case (s)
      DECODE_ADDRESS: begin
        o.detect_add = 1'b1;
      end
      LOAD_FIRST_DATA: begin
        o.lfd_state = 1'b1;
        o.busy      = 1'b1;
      end
      LOAD_DATA: begin
        o.ld_state      = 1'b1;
        o.write_enb_reg = 1'b1;
      end
      FIFO_FULL_STATE: begin
        o.full_state = 1'b1;
        o.busy       = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        o.laf_state     = 1'b1;
        o.write_enb_reg = 1'b1;
        o.busy          = 1'b1;
      end
      LOAD_PARITY: begin
        o.write_enb_reg = 1'b1;
        o.busy          = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        o.rst_int_reg = 1'b1;
        o.busy        = 1'b1;
      end
      WAIT_TILL_EMPTY: begin
        o.busy = 1'b1;
      end
      default: begin
        o = '0;
      end
    endcase
    return o;
  endfunction

  // Pick the per-port flag belonging to a destination address; the
  // invalid address selects nothing.
  function automatic logic sel_port(input logic [2:0] flags, input logic [1:0] addr);
    logic r;
    case (addr)
      ADDR0:   r = flags[0];
      ADDR1:   r = flags[1];
      ADDR2:   r = flags[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/router_ctrl_fsm.sv
// Control FSM of a 1-in/3-out packet router. Decodes the destination,
// sequences header/payload/parity loading and handles full/busy stalls.
// Output strobes are registered from the next-state decode so they line
// up with the state register without any input-to-output path.
module router_ctrl_fsm
  import router_ctrl_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_rst_0,
  input  logic       soft_rst_1,
  input  logic       soft_rst_2,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg
);

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  ctrl_out_t  out_q, out_d;

  logic [2:0] empty_s;
  logic [2:0] soft_rst_s;
  logic       soft_hit_s;

  assign empty_s    = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_rst_s = {soft_rst_2, soft_rst_1, soft_rst_0};

  // Next-state, address capture and next-output decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    soft_hit_s = sel_port(soft_rst_s, addr_q);

    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && (data_in != ADDR_INVALID)) begin
          addr_d = data_in;
          if (sel_port(empty_s, data_in)) begin
            state_d = LOAD_FIRST_DATA;
          end else begin
            state_d = WAIT_TILL_EMPTY;
          end
        end else begin
          state_d = DECODE_ADDRESS;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (sel_port(empty_s, addr_q)) begin
          state_d = LOAD_FIRST_DATA;
        end else begin
          state_d = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: begin
        state_d = LOAD_DATA;
      end
      LOAD_DATA: begin
        // A full FIFO takes precedence over the end of payload.
        if (fifo_full) begin
          state_d = FIFO_FULL_STATE;
        end else if (!pkt_valid) begin
          state_d = LOAD_PARITY;
        end else begin
          state_d = LOAD_DATA;
        end
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) begin
          state_d = LOAD_AFTER_FULL;
        end else begin
          state_d = FIFO_FULL_STATE;
        end
      end
      LOAD_AFTER_FULL: begin
        // Parity already captured means the packet is complete.
        if (parity_done) begin
          state_d = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          state_d = LOAD_PARITY;
        end else begin
          state_d = LOAD_DATA;
        end
      end
      LOAD_PARITY: begin
        state_d = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: begin
        if (fifo_full) begin
          state_d = FIFO_FULL_STATE;
        end else begin
          state_d = DECODE_ADDRESS;
        end
      end
      default: begin
        state_d = DECODE_ADDRESS;
      end
    endcase

    // Timeout soft reset of the addressed port aborts the packet.
    if ((state_q != DECODE_ADDRESS) && soft_hit_s) begin
      state_d = DECODE_ADDRESS;
    end else begin
      state_d = state_d;
    end

    out_d = decode_outputs(state_d);
  end

  // State, address and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= ADDR0;
      out_q   <= decode_outputs(DECODE_ADDRESS);
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
    end
  end

  assign busy          = out_q.busy;
  assign detect_add    = out_q.detect_add;
  assign lfd_state     = out_q.lfd_state;
  assign ld_state      = out_q.ld_state;
  assign full_state    = out_q.full_state;
  assign laf_state     = out_q.laf_state;
  assign write_enb_reg = out_q.write_enb_reg;
  assign rst_int_reg   = out_q.rst_int_reg;

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed, table-driven bench for router_ctrl_fsm. Each row gives the
// inputs held across one rising edge and the output vector expected after it.
module tb_router_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_rst_0, soft_rst_1, soft_rst_2;
  logic       busy, detect_add, lfd_state, ld_state, full_state, laf_state;
  logic       write_enb_reg, rst_int_reg;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected output vectors {busy,detect_add,lfd,ld,full,laf,write_enb,rst_int}
  localparam logic [7:0] E_DA  = 8'b0100_0000;
  localparam logic [7:0] E_LFD = 8'b1010_0000;
  localparam logic [7:0] E_LD  = 8'b0001_0010;
  localparam logic [7:0] E_FFS = 8'b1000_1000;
  localparam logic [7:0] E_LAF = 8'b1000_0110;
  localparam logic [7:0] E_LP  = 8'b1000_0010;
  localparam logic [7:0] E_CPE = 8'b1000_0001;
  localparam logic [7:0] E_WTE = 8'b1000_0000;

  typedef struct {
    logic       rst;
    logic       pv;
    logic [1:0] din;
    logic       pdone;
    logic       lpv;
    logic       full;
    logic [2:0] empty;
    logic [2:0] srst;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  router_ctrl_fsm dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_rst_0(soft_rst_0), .soft_rst_1(soft_rst_1), .soft_rst_2(soft_rst_2),
    .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .full_state(full_state), .laf_state(laf_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {busy, detect_add, lfd_state, ld_state, full_state, laf_state,
            write_enb_reg, rst_int_reg};
  endfunction

  task automatic add(input logic r, input logic pv, input logic [1:0] din,
                     input logic pd, input logic lpv, input logic full,
                     input logic [2:0] empty, input logic [2:0] srst,
                     input logic [7:0] exp);
    vec_t v;
    v.rst = r; v.pv = pv; v.din = din; v.pdone = pd; v.lpv = lpv;
    v.full = full; v.empty = empty; v.srst = srst; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; pkt_valid = v.pv; data_in = v.din; parity_done = v.pdone;
    low_pkt_valid = v.lpv; fifo_full = v.full;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = v.empty;
    {soft_rst_2, soft_rst_1, soft_rst_0} = v.srst;
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = outs();
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %b expected %b", name, act, exp);
    end
  endtask

  // Apply one row across a rising edge and compare 1 time unit later.
  task automatic step(input vec_t v, input string name);
    drive(v);
    @(posedge clk);
    #1;
    check(name, v.exp);
  endtask

  initial begin
    vec_t v;
    //   rst pv din pd lpv full empty   srst    expected
    add(1, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_DA);   // reset
    // normal packet to port 1
    add(0, 1, 1, 0, 0, 0, 3'b111, 3'b000, E_LFD);
    add(0, 1, 0, 0, 0, 0, 3'b111, 3'b000, E_LD);
    add(0, 1, 0, 0, 0, 0, 3'b111, 3'b000, E_LD);
    add(0, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_LP);
    add(0, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_CPE);
    add(0, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_DA);
    // full stall on port 0, released via low_pkt_valid
    add(0, 1, 0, 0, 0, 0, 3'b111, 3'b000, E_LFD);
    add(0, 1, 0, 0, 0, 0, 3'b111, 3'b000, E_LD);
    add(0, 1, 0, 0, 0, 1, 3'b111, 3'b000, E_FFS);
    add(0, 1, 0, 0, 0, 1, 3'b111, 3'b000, E_FFS);
    add(0, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_LAF);
    add(0, 0, 0, 0, 1, 0, 3'b111, 3'b000, E_LP);
    add(0, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_CPE);
    add(0, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_DA);
    // full beats !pkt_valid in LD; parity_done beats low_pkt_valid in LAF
    add(0, 1, 0, 0, 0, 0, 3'b111, 3'b000, E_LFD);
    add(0, 0, 0, 0, 0, 1, 3'b111, 3'b000, E_LD);
    add(0, 0, 0, 0, 0, 1, 3'b111, 3'b000, E_FFS);
    add(0, 0, 0, 1, 1, 0, 3'b111, 3'b000, E_LAF);
    add(0, 0, 0, 1, 1, 0, 3'b111, 3'b000, E_DA);
    // full in CPE goes back to FFS; LAF with neither flag returns to LD
    add(0, 1, 0, 0, 0, 0, 3'b111, 3'b000, E_LFD);
    add(0, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_LD);
    add(0, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_LP);
    add(0, 0, 0, 0, 0, 1, 3'b111, 3'b000, E_CPE);
    add(0, 0, 0, 0, 0, 1, 3'b111, 3'b000, E_FFS);
    add(0, 1, 0, 0, 0, 0, 3'b111, 3'b000, E_LAF);
    add(0, 1, 0, 0, 0, 0, 3'b111, 3'b000, E_LD);
    add(0, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_LP);
    add(0, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_CPE);
    add(0, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_DA);
    // port 2 busy: wait uses latched address, not data_in
    add(0, 1, 2, 0, 0, 0, 3'b011, 3'b000, E_WTE);
    add(0, 0, 0, 0, 0, 0, 3'b011, 3'b000, E_WTE);
    add(0, 0, 0, 0, 0, 0, 3'b011, 3'b000, E_WTE);
    add(0, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_LFD);
    add(0, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_LD);
    add(0, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_LP);
    add(0, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_CPE);
    add(0, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_DA);
    // soft reset: non-addressed ignored, addressed aborts
    add(0, 1, 1, 0, 0, 0, 3'b111, 3'b000, E_LFD);
    add(0, 1, 0, 0, 0, 0, 3'b111, 3'b000, E_LD);
    add(0, 1, 0, 0, 0, 0, 3'b111, 3'b001, E_LD);
    add(0, 1, 0, 0, 0, 0, 3'b111, 3'b010, E_DA);
    add(0, 0, 0, 0, 0, 0, 3'b111, 3'b010, E_DA);
    // invalid address ignored
    add(0, 1, 3, 0, 0, 0, 3'b111, 3'b000, E_DA);
    add(0, 1, 3, 0, 0, 0, 3'b111, 3'b000, E_DA);
    // soft reset out of WAIT_TILL_EMPTY on port 0
    add(0, 1, 0, 0, 0, 0, 3'b110, 3'b000, E_WTE);
    add(0, 0, 0, 0, 0, 0, 3'b110, 3'b001, E_DA);
    // rst mid-packet, with a competing full flag
    add(0, 1, 1, 0, 0, 0, 3'b111, 3'b000, E_LFD);
    add(0, 1, 0, 0, 0, 0, 3'b111, 3'b000, E_LD);
    add(1, 1, 0, 0, 0, 1, 3'b111, 3'b010, E_DA);
    add(0, 1, 1, 0, 0, 0, 3'b111, 3'b000, E_LFD);
    add(0, 1, 1, 0, 0, 0, 3'b111, 3'b000, E_LD);
    add(1, 0, 0, 0, 0, 0, 3'b111, 3'b000, E_DA);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Hand sequence: long stall in FFS on port 2, then soft_rst_2 aborts it.
    v = '{rst:0, pv:1, din:2, pdone:0, lpv:0, full:0, empty:3'b111, srst:3'b000, exp:E_LFD};
    step(v, "hs_lfd");
    v.pv = 1'b1; v.din = 2'd0; v.exp = E_LD;
    step(v, "hs_ld");
    v.full = 1'b1; v.exp = E_FFS;
    for (int k = 0; k < 8; k++) begin
      step(v, $sformatf("hs_stall%0d", k));
    end
    v.srst = 3'b011; v.exp = E_FFS;
    step(v, "hs_srst_other");
    v.srst = 3'b100; v.exp = E_DA;
    step(v, "hs_srst_addr");

    // Hand sequence: wait for empty with a cycle budget, empty rises later.
    v = '{rst:0, pv:1, din:1, pdone:0, lpv:0, full:0, empty:3'b101, srst:3'b000, exp:E_WTE};
    step(v, "hw_wte");
    v.pv = 1'b0;
    begin
      int budget;
      budget = 0;
      drive(v);
      fork
        begin
          repeat (5) @(posedge clk);
          #2;
          fifo_empty_1 = 1'b1;
        end
      join_none
      while (lfd_state !== 1'b1 && budget < 20) begin
        @(posedge clk);
        #1;
        budget++;
        if (lfd_state !== 1'b1) begin
          check($sformatf("hw_wait%0d", budget), E_WTE);
        end
      end
      check("hw_lfd_reached", E_LFD);
      n_cmp++;
      if (budget != 6) begin
        n_fail++;
        $display("FAIL hw_latency: cycles got %0d expected 6", budget);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/router_ctrl_fsm.md
# router_ctrl_fsm

Control state machine of a 1-input/3-output packet router. It decodes the 2-bit destination address of an incoming packet and sequences header, payload and parity loading into the register/FIFO datapath. It stalls on a full destination FIFO and waits for a busy destination to drain. It sits between the input register block (which consumes its state strobes) and the three output FIFOs (which supply empty/full and soft-reset status).

## Interface
No parameters. One clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- pkt_valid  in  1  high while header/payload bytes are presented; falls at the parity byte
- data_in  in  2  destination address (header bits [1:0]); 3 is invalid
- parity_done  in  1  parity byte captured by datapath
- low_pkt_valid  in  1  datapath saw pkt_valid fall while FIFO was full
- fifo_full  in  1  full flag of currently addressed FIFO
- fifo_empty_0/1/2  in  1 each  empty flags of output FIFOs
- soft_rst_0/1/2  in  1 each  per-FIFO timeout soft reset
- busy  out  1  stall upstream source
- detect_add  out  1  in DECODE_ADDRESS
- lfd_state  out  1  in LOAD_FIRST_DATA
- ld_state  out  1  in LOAD_DATA
- full_state  out  1  in FIFO_FULL_STATE
- laf_state  out  1  in LOAD_AFTER_FULL
- write_enb_reg  out  1  write enable toward FIFOs
- rst_int_reg  out  1  clear internal parity/error registers

## Operation
- Eight states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- 2-bit address register `addr` loads data_in on every cycle spent in DECODE_ADDRESS with pkt_valid=1 and data_in≠3.
- DECODE_ADDRESS: pkt_valid and data_in=k (k<3) and fifo_empty_k → LOAD_FIRST_DATA. pkt_valid and data_in=k and !fifo_empty_k → WAIT_TILL_EMPTY. Otherwise stay; data_in=3 is ignored.
- WAIT_TILL_EMPTY: fifo_empty_[addr] → LOAD_FIRST_DATA; else stay.
- LOAD_FIRST_DATA → LOAD_DATA unconditionally.
- LOAD_DATA: fifo_full → FIFO_FULL_STATE. Else !pkt_valid → LOAD_PARITY. Else stay.
- FIFO_FULL_STATE: !fifo_full → LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL: parity_done → DECODE_ADDRESS. Else low_pkt_valid → LOAD_PARITY. Else → LOAD_DATA.
- LOAD_PARITY → CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full → FIFO_FULL_STATE; else → DECODE_ADDRESS.
- Soft reset: soft_rst_[addr]=1 in any state other than DECODE_ADDRESS → DECODE_ADDRESS next cycle. Overrides all other transitions. Soft resets of non-addressed ports are ignored.
- Outputs are Moore decodes of the state register only:
  - detect_add, lfd_state, ld_state, full_state, laf_state: one each per named state.
  - rst_int_reg = CHECK_PARITY_ERROR.
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.

## Timing
- Synchronous reset: state = DECODE_ADDRESS, addr = 0. Outputs after reset: detect_add=1, all other outputs 0.
- rst has priority over soft reset and over all transitions. Asserting rst mid-packet returns to DECODE_ADDRESS on the next edge.
- Transitions take effect on the rising edge after the inputs are sampled. Outputs change in the same cycle as the state. No combinational input-to-output paths.
- Minimum packet with an empty, non-full FIFO: DECODE → LFD → LD (≥1 cycle) → LP → CPE → DECODE.
- Simultaneous fifo_full and !pkt_valid in LOAD_DATA: full wins.
- Simultaneous parity_done and low_pkt_valid in LOAD_AFTER_FULL: parity_done wins.

## Structure
- A shared package holds the state enum (3-bit encoding) and the address constants ADDR0..ADDR2 and ADDR_INVALID=3.
- Single module with next-state logic, state register, address register and output decode. No sub-module.

## Test plan
- Reset: rst=1 for 1 cycle → detect_add=1, busy=0, write_enb_reg=0.
- Normal packet to port 1 (fifo_empty_1=1, pkt_valid=1 for 3 cycles, then 0) → DECODE, LFD (busy=1), LD×2 (write_enb_reg=1, busy=0), LP, CPE (rst_int_reg=1), DECODE.
- Full stall on port 0: fifo_full=1 during LD → FIFO_FULL_STATE (busy=1, write_enb_reg=0). Release with low_pkt_valid=1, parity_done=0 → LAF then LP then CPE.
- Port 2 with fifo_empty_2=0 → WAIT_TILL_EMPTY (busy=1) until fifo_empty_2=1, then LFD.
- LAF with parity_done=1 → DECODE_ADDRESS directly. fifo_full=1 in CPE → FIFO_FULL_STATE.
- soft_rst_1 while in LD for addr=1 → DECODE_ADDRESS next cycle. soft_rst_0 in the same situation → no effect. data_in=3 with pkt_valid=1 → stays in DECODE_ADDRESS.
